// File: rtl/sched_pkg.sv
// Shared sizing defaults and FSM state encoding for the VOQ scheduler.
package sched_pkg;

    localparam int unsigned INGRESS_CNT_DEF = 4;
    localparam int unsigned EGRESS_CNT_DEF  = 4;

    typedef logic [1:0] sched_state_t;

    localparam sched_state_t StIdle   = 2'd0;
    localparam sched_state_t StGrant  = 2'd1;
    localparam sched_state_t StAccept = 2'd2;
    localparam sched_state_t StIssue  = 2'd3;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after ptr_i, wrapping.
module rr_arbiter #(
    parameter int unsigned N    = 4,
    parameter int unsigned PtrW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req_i,
    input  logic [PtrW-1:0] ptr_i,
    output logic [N-1:0]    gnt_o,
    output logic            valid_o
);

    logic            found;
    logic [PtrW-1:0] idx;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = PtrW'((32'(ptr_i) + k) % N);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/voq_scheduler.sv
// Single-iteration iSLIP-style VOQ scheduler: sample requests, grant, accept, issue dequeues.
module voq_scheduler
    import sched_pkg::*;
#(
    parameter int unsigned INGRESS_CNT = INGRESS_CNT_DEF,
    parameter int unsigned EGRESS_CNT  = EGRESS_CNT_DEF
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     sched_start,
    input  logic [INGRESS_CNT*EGRESS_CNT-1:0]        voq_empty,
    output logic [INGRESS_CNT-1:0]                   voq_dequeue_en,
    output logic [INGRESS_CNT*$clog2(EGRESS_CNT)-1:0] voq_dequeue_sel,
    output logic                                     sched_done,
    output logic                                     busy
);

    localparam int unsigned IW = $clog2(INGRESS_CNT);
    localparam int unsigned EW = $clog2(EGRESS_CNT);

    sched_state_t state_q, state_d;

    // req/accept indexed [ingress][egress]; grant indexed [egress][ingress]
    logic [INGRESS_CNT-1:0][EGRESS_CNT-1:0] req_q, req_d;
    logic [EGRESS_CNT-1:0][INGRESS_CNT-1:0] grant_q, grant_d;
    logic [INGRESS_CNT-1:0][EGRESS_CNT-1:0] accept_q, accept_d;
    logic [EGRESS_CNT-1:0][IW-1:0]          g_ptr_q, g_ptr_d;
    logic [INGRESS_CNT-1:0][EW-1:0]         a_ptr_q, a_ptr_d;

    logic [EGRESS_CNT-1:0][INGRESS_CNT-1:0] col_req, gnt_vec;
    logic [INGRESS_CNT-1:0][EGRESS_CNT-1:0] acc_req, acc_vec;
    logic [EGRESS_CNT-1:0]                  gnt_valid;
    logic [INGRESS_CNT-1:0]                 acc_valid;

    always_comb begin
        col_req = '0;
        acc_req = '0;
        for (int i = 0; i < INGRESS_CNT; i++) begin
            for (int e = 0; e < EGRESS_CNT; e++) begin
                col_req[e][i] = req_q[i][e];
                acc_req[i][e] = grant_q[e][i];
            end
        end
    end

    for (genvar e = 0; e < EGRESS_CNT; e++) begin : g_grant
        rr_arbiter #(
            .N    (INGRESS_CNT),
            .PtrW (IW)
        ) u_arb (
            .req_i   (col_req[e]),
            .ptr_i   (g_ptr_q[e]),
            .gnt_o   (gnt_vec[e]),
            .valid_o (gnt_valid[e])
        );
    end

    for (genvar i = 0; i < INGRESS_CNT; i++) begin : g_accept
        rr_arbiter #(
            .N    (EGRESS_CNT),
            .PtrW (EW)
        ) u_arb (
            .req_i   (acc_req[i]),
            .ptr_i   (a_ptr_q[i]),
            .gnt_o   (acc_vec[i]),
            .valid_o (acc_valid[i])
        );
    end

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        grant_d  = grant_q;
        accept_d = accept_q;
        case (state_q)
            StIdle: begin
                if (sched_start) begin
                    req_d   = ~voq_empty;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                for (int e = 0; e < EGRESS_CNT; e++) begin
                    grant_d[e] = gnt_valid[e] ? gnt_vec[e] : '0;
                end
                state_d = StAccept;
            end
            StAccept: begin
                for (int i = 0; i < INGRESS_CNT; i++) begin
                    accept_d[i] = acc_valid[i] ? acc_vec[i] : '0;
                end
                state_d = StIssue;
            end
            default: state_d = StIdle;
        endcase
    end

    // Issue strobes and pointer advance come straight from the registered accepts
    always_comb begin
        voq_dequeue_en  = '0;
        voq_dequeue_sel = '0;
        g_ptr_d         = g_ptr_q;
        a_ptr_d         = a_ptr_q;
        if (state_q == StIssue) begin
            for (int i = 0; i < INGRESS_CNT; i++) begin
                for (int e = 0; e < EGRESS_CNT; e++) begin
                    if (accept_q[i][e]) begin
                        voq_dequeue_en[i]            = 1'b1;
                        voq_dequeue_sel[i*EW +: EW]  = EW'(e);
                        a_ptr_d[i]                   = EW'((e + 1) % EGRESS_CNT);
                        g_ptr_d[e]                   = IW'((i + 1) % INGRESS_CNT);
                    end
                end
            end
        end
    end

    assign sched_done = (state_q == StIssue);
    assign busy       = (state_q != StIdle);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            req_q    <= '0;
            grant_q  <= '0;
            accept_q <= '0;
            g_ptr_q  <= '0;
            a_ptr_q  <= '0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            grant_q  <= grant_d;
            accept_q <= accept_d;
            g_ptr_q  <= g_ptr_d;
            a_ptr_q  <= a_ptr_d;
        end
    end

endmodule

// File: tb/tb_voq_scheduler.sv
// Directed, table-driven bench for voq_scheduler at the default 4x4 size.
module tb_voq_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        sched_start;
    logic [15:0] voq_empty;
    logic [3:0]  voq_dequeue_en;
    logic [7:0]  voq_dequeue_sel;
    logic        sched_done;
    logic        busy;

    int checks = 0;
    int errors = 0;

    voq_scheduler #(
        .INGRESS_CNT (4),
        .EGRESS_CNT  (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .sched_start     (sched_start),
        .voq_empty       (voq_empty),
        .voq_dequeue_en  (voq_dequeue_en),
        .voq_dequeue_sel (voq_dequeue_sel),
        .sched_done      (sched_done),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic [15:0] empty;
        logic [3:0]  en;
        logic [7:0]  sel;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " en"}, 32'(voq_dequeue_en), 32'h0);
        check({tag, " sel"}, 32'(voq_dequeue_sel), 32'h0);
        check({tag, " done"}, 32'(sched_done), 32'h0);
        check({tag, " busy"}, 32'(busy), 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset       = 1'b1;
        sched_start = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;
    endtask

    // Start one round, disturb voq_empty during GRANT, check every cycle through ISSUE.
    task automatic run_round(input logic [15:0] empty, input logic [3:0] exp_en,
                             input logic [7:0] exp_sel, input string tag);
        @(negedge clk);
        voq_empty   = empty;
        sched_start = 1'b1;
        @(negedge clk);
        sched_start = 1'b0;
        voq_empty   = ~empty;
        check({tag, " grant busy"}, 32'(busy), 32'h1);
        check({tag, " grant en"}, 32'(voq_dequeue_en), 32'h0);
        @(negedge clk);
        check({tag, " accept en"}, 32'(voq_dequeue_en), 32'h0);
        check({tag, " accept done"}, 32'(sched_done), 32'h0);
        @(negedge clk);
        check({tag, " issue en"}, 32'(voq_dequeue_en), 32'(exp_en));
        check({tag, " issue sel"}, 32'(voq_dequeue_sel), 32'(exp_sel));
        check({tag, " issue done"}, 32'(sched_done), 32'h1);
        @(negedge clk);
        check_idle_outputs({tag, " after"});
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int dones;

        reset       = 1'b1;
        sched_start = 1'b0;
        voq_empty   = '1;

        // sel packs field i at [2i+1:2i]
        vecs[0] = '{rst: 1'b1, empty: 16'hFFFF, en: 4'b0000, sel: 8'h00};
        vecs[1] = '{rst: 1'b0, empty: 16'h0000, en: 4'b0001, sel: 8'h00};
        vecs[2] = '{rst: 1'b0, empty: 16'h0000, en: 4'b0011, sel: 8'h01};
        vecs[3] = '{rst: 1'b0, empty: 16'h0000, en: 4'b0111, sel: 8'h06};
        vecs[4] = '{rst: 1'b0, empty: 16'h0000, en: 4'b1111, sel: 8'h1B};
        vecs[5] = '{rst: 1'b0, empty: 16'h0000, en: 4'b1111, sel: 8'h6C};
        vecs[6] = '{rst: 1'b1, empty: 16'hFFBB, en: 4'b0001, sel: 8'h02};
        vecs[7] = '{rst: 1'b0, empty: 16'hFFBB, en: 4'b0010, sel: 8'h08};
        vecs[8] = '{rst: 1'b0, empty: 16'hFFBB, en: 4'b0001, sel: 8'h02};

        do_reset();

        for (int v = 0; v < 9; v++) begin
            if (vecs[v].rst) do_reset();
            run_round(vecs[v].empty, vecs[v].en, vecs[v].sel, $sformatf("vec%0d", v));
        end

        // Start held high for 4 cycles: one round only, then pointers advanced once.
        do_reset();
        dones = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (sched_done) dones++;
            if (k == 3) begin
                check("held issue en", 32'(voq_dequeue_en), 32'h1);
            end
            voq_empty   = 16'h0000;
            sched_start = (k < 4);
        end
        check("held done count", 32'(dones), 32'd1);
        run_round(16'h0000, 4'b0011, 8'h01, "held next");

        // Reset in ACCEPT: round abandoned, pointers cleared.
        do_reset();
        run_round(16'h0000, 4'b0001, 8'h00, "pre midrst");
        @(negedge clk);
        voq_empty   = 16'h0000;
        sched_start = 1'b1;
        @(negedge clk);
        sched_start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_idle_outputs("midrst");
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("midrst quiet%0d en", k), 32'(voq_dequeue_en), 32'h0);
        end
        run_round(16'h0000, 4'b0001, 8'h00, "post midrst");

        // Reset wins over a simultaneous start.
        @(negedge clk);
        reset       = 1'b1;
        sched_start = 1'b1;
        @(negedge clk);
        check("rst prio busy", 32'(busy), 32'h0);
        reset       = 1'b0;
        sched_start = 1'b0;
        @(negedge clk);
        check("rst prio busy later", 32'(busy), 32'h0);

        // Requests changed during GRANT and ACCEPT must not affect the match.
        do_reset();
        @(negedge clk);
        voq_empty   = 16'hFFBB;
        sched_start = 1'b1;
        @(negedge clk);
        sched_start = 1'b0;
        voq_empty   = 16'h0000;
        @(negedge clk);
        voq_empty = 16'hFFFF;
        @(negedge clk);
        check("reqchg en", 32'(voq_dequeue_en), 32'h1);
        check("reqchg sel", 32'(voq_dequeue_sel), 32'h02);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
